shuffle_lane_buf: RTL and testbench
===================================

Name: shuffle_lane_buf

Overview:
- Elastic buffer directly downstream of the 8-lane shuffle stage.
- Captures the eight 256-bit shuffled lanes as one beat and holds them in a small FIFO.
- Presents them with valid/ready to the 2D PE array.
- Tracks beats per NTT/polymul stage and pulses a stage-done strobe for the controller.
- Decouples the combinational shuffle from PE-array stalls.

Parameters:
- WIDTH, 256, bits per lane.
- DEPTH, 4, FIFO entries, each holding 8 lanes. Power of two, at least 2.
- BEATS, 8, beats per stage. Power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO contents and counters.
- in_valid  input  1  upstream beat valid, driven by the shuffle enable.
- in_ready  output  1  buffer can accept a beat.
- in_data_0..in_data_7  input  WIDTH each  shuffled lanes 0..7.
- out_valid  output  1  head beat available.
- out_ready  input  1  PE array accepts the head beat.
- out_data_0..out_data_7  output  WIDTH each  head beat lanes 0..7.
- out_beat_idx  output  log2(BEATS)  index of the head beat within the current stage.
- stage_done  output  1  one-cycle pulse after the last beat of a stage is popped.
- level  output  log2(DEPTH)+1  number of occupied entries.
- ovf_err  output  1  sticky; set by an attempted push while full.

Behaviour:
Reset values (rst high, asynchronous):
- Read pointer, write pointer and level are 0.
- in_ready is 1 and out_valid is 0.
- out_data_* are 0; out_beat_idx is 0; stage_done is 0; ovf_err is 0.
- Storage contents are don't-care.

Handshake definitions:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (level != DEPTH). It is combinational from registered state only, with no dependence on out_ready.
- out_valid = (level != 0).
- out_data_* show storage at the read pointer (first-word fall-through).
- out_data_* are forced to 0 when out_valid is 0.

Latency:
- A beat pushed into an empty buffer at edge N gives out_valid = 1 and the data valid after edge N.
- There is no combinational in-to-out path.

Per-edge update (flush not active):
- On push: write all 8 lanes at the write pointer, then increment the write pointer modulo DEPTH.
- On pop: increment the read pointer modulo DEPTH.
- level:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Push and pop together when not full or empty: both complete.
- Full: in_ready = 0, so no push, and a pop frees an entry for the next cycle.
- Empty: out_valid = 0, so no pop, and a push is accepted.

Beat counter (out_beat_idx):
- Increments on each pop.
- On the pop where out_beat_idx = BEATS-1, it wraps to 0 and stage_done is set to 1 for the next cycle only.
- Otherwise stage_done is 0.

Flush:
- When flush is high at an edge, it clears pointers, level, out_beat_idx and stage_done.
- It has priority over a same-cycle push or pop; those are discarded.
- ovf_err is not cleared by flush, only by rst.

ovf_err:
- Set when in_valid = 1 and level = DEPTH at an edge (upstream ignored backpressure).
- The beat is dropped and the stored data is unchanged.

Reset mid-operation:
- Asserting rst at any time immediately forces the reset values above.
- Any partial stage is discarded.

Widths:
- Pointers are log2(DEPTH) bits and wrap naturally.
- level is one bit wider so that full is distinguished from empty.

Test Plan:
- Reset, then a single push of lanes 0x1..0x8 with out_ready = 0 -> out_valid = 1 and out_data_k = k+1 on the next cycle, level = 1. Raise out_ready -> level = 0 and out_valid = 0 the cycle after.
- 4 pushes with out_ready held 0 (DEPTH = 4) -> level = 4, in_ready = 0. A 5th in_valid -> ovf_err = 1 and data unchanged. Pop 4 -> data in order, in_ready back to 1 after the first pop.
- Continuous push and pop with in_valid = out_ready = 1 for 16 beats -> level stays at 1 after the first beat. out_beat_idx cycles 0..7 twice. stage_done pulses exactly twice, each the cycle after the idx = 7 pop.
- Random out_ready stalls (50 %) over 64 incrementing beats -> the output sequence equals the input sequence with no loss or duplication, and level never exceeds 4.
- Push 3 beats and pop 2 (out_beat_idx = 2), then assert flush with in_valid = 1 -> level = 0, out_valid = 0, out_beat_idx = 0, the flushed push is discarded, and ovf_err is unchanged.
- Assert rst asynchronously between edges with level = 3 -> all outputs take reset values immediately. The next push after release appears with out_beat_idx = 0.

Source files
------------

// File: rtl/shuffle_lane_buf.sv
// rtl/shuffle_lane_buf.sv - 8-lane elastic FIFO between the shuffle stage and the PE array
module shuffle_lane_buf #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4,
  parameter int BEATS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data_0,
  input  logic [WIDTH-1:0]           in_data_1,
  input  logic [WIDTH-1:0]           in_data_2,
  input  logic [WIDTH-1:0]           in_data_3,
  input  logic [WIDTH-1:0]           in_data_4,
  input  logic [WIDTH-1:0]           in_data_5,
  input  logic [WIDTH-1:0]           in_data_6,
  input  logic [WIDTH-1:0]           in_data_7,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data_0,
  output logic [WIDTH-1:0]           out_data_1,
  output logic [WIDTH-1:0]           out_data_2,
  output logic [WIDTH-1:0]           out_data_3,
  output logic [WIDTH-1:0]           out_data_4,
  output logic [WIDTH-1:0]           out_data_5,
  output logic [WIDTH-1:0]           out_data_6,
  output logic [WIDTH-1:0]           out_data_7,
  output logic [$clog2(BEATS)-1:0]   out_beat_idx,
  output logic                       stage_done,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BEATS);
  localparam int LANES = 8;
  localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] L_LAST = BW'(BEATS-1);

  logic [WIDTH-1:0] r_mem [DEPTH][LANES];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [BW-1:0]    r_beat_idx;
  logic             r_stage_done;
  logic             r_ovf_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_in_lanes  [LANES];
  logic [WIDTH-1:0] w_out_lanes [LANES];

  assign w_in_lanes[0] = in_data_0;
  assign w_in_lanes[1] = in_data_1;
  assign w_in_lanes[2] = in_data_2;
  assign w_in_lanes[3] = in_data_3;
  assign w_in_lanes[4] = in_data_4;
  assign w_in_lanes[5] = in_data_5;
  assign w_in_lanes[6] = in_data_6;
  assign w_in_lanes[7] = in_data_7;

  // Ready/valid come only from registered occupancy, so no in-to-out path exists
  assign w_full    = (r_level == L_FULL);
  assign w_empty   = (r_level == '0);
  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & ~w_full;
  assign w_pop     = ~w_empty & out_ready;

  // Beat storage; contents are don't-care after reset, and a flushed push is dropped
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      for (int k = 0; k < LANES; k++) begin
        r_mem[r_wr_ptr][k] <= w_in_lanes[k];
      end
    end
  end

  // Pointers, occupancy and per-stage beat tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_beat_idx   <= '0;
      r_stage_done <= 1'b0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_beat_idx   <= '0;
      r_stage_done <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_beat_idx <= r_beat_idx + BW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      r_stage_done <= w_pop && (r_beat_idx == L_LAST);
    end
  end

  // Sticky overflow: upstream drove a beat while we were full; only rst clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_err <= 1'b0;
    end else if (in_valid && w_full) begin
      r_ovf_err <= 1'b1;
    end
  end

  // First-word fall-through head, zeroed while empty
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_out_lanes[k] = w_empty ? '0 : r_mem[r_rd_ptr][k];
    end
  end

  assign out_data_0   = w_out_lanes[0];
  assign out_data_1   = w_out_lanes[1];
  assign out_data_2   = w_out_lanes[2];
  assign out_data_3   = w_out_lanes[3];
  assign out_data_4   = w_out_lanes[4];
  assign out_data_5   = w_out_lanes[5];
  assign out_data_6   = w_out_lanes[6];
  assign out_data_7   = w_out_lanes[7];
  assign out_beat_idx = r_beat_idx;
  assign stage_done   = r_stage_done;
  assign level        = r_level;
  assign ovf_err      = r_ovf_err;

endmodule

// File: tb/tb_shuffle_lane_buf.sv
// tb/tb_shuffle_lane_buf.sv - directed self-checking bench for shuffle_lane_buf
module tb_shuffle_lane_buf;
  localparam int W = 256;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data_0, in_data_1, in_data_2, in_data_3;
  logic [W-1:0] in_data_4, in_data_5, in_data_6, in_data_7;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data_0, out_data_1, out_data_2, out_data_3;
  logic [W-1:0] out_data_4, out_data_5, out_data_6, out_data_7;
  logic [2:0]   out_beat_idx;
  logic         stage_done;
  logic [2:0]   level;
  logic         ovf_err;

  int total = 0;
  int bad   = 0;

  shuffle_lane_buf #(.WIDTH(W), .DEPTH(4), .BEATS(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_0(in_data_0), .in_data_1(in_data_1), .in_data_2(in_data_2), .in_data_3(in_data_3),
    .in_data_4(in_data_4), .in_data_5(in_data_5), .in_data_6(in_data_6), .in_data_7(in_data_7),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_0(out_data_0), .out_data_1(out_data_1), .out_data_2(out_data_2), .out_data_3(out_data_3),
    .out_data_4(out_data_4), .out_data_5(out_data_5), .out_data_6(out_data_6), .out_data_7(out_data_7),
    .out_beat_idx(out_beat_idx), .stage_done(stage_done), .level(level), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [W-1:0] base);
    in_data_0 = base + 0; in_data_1 = base + 1; in_data_2 = base + 2; in_data_3 = base + 3;
    in_data_4 = base + 4; in_data_5 = base + 5; in_data_6 = base + 6; in_data_7 = base + 7;
  endtask

  function automatic logic [W-1:0] olane(input int k);
    case (k)
      0: return out_data_0;
      1: return out_data_1;
      2: return out_data_2;
      3: return out_data_3;
      4: return out_data_4;
      5: return out_data_5;
      6: return out_data_6;
      default: return out_data_7;
    endcase
  endfunction

  int tx, rx, maxlvl, pulses;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in('0);
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_data0", out_data_0, 0);
    chk("rst_idx", out_beat_idx, 0);
    chk("rst_stage_done", stage_done, 0);
    chk("rst_ovf", ovf_err, 0);
    tick();
    rst = 1'b0;

    // single beat, lanes 1..8
    in_valid = 1'b1; set_in(1);
    tick();
    in_valid = 1'b0;
    chk("one_valid", out_valid, 1);
    chk("one_level", level, 1);
    chk("one_idx", out_beat_idx, 0);
    for (int k = 0; k < 8; k++) chk($sformatf("one_lane%0d", k), olane(k), k + 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_pop_level", level, 0);
    chk("one_pop_valid", out_valid, 0);
    chk("one_pop_data0", out_data_0, 0);
    chk("one_pop_idx", out_beat_idx, 1);

    // fill to full, then overflow attempt
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; set_in(256'h10 * i);
      tick();
    end
    chk("full_level", level, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_ovf_pre", ovf_err, 0);
    set_in(256'h50);
    tick();
    in_valid = 1'b0;
    chk("ovf_set", ovf_err, 1);
    chk("ovf_level", level, 4);
    chk("ovf_head", out_data_0, 256'h10);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d_d0", i), out_data_0, 256'h10 * i);
      chk($sformatf("drain%0d_d7", i), out_data_7, 256'h10 * i + 7);
      tick();
      if (i == 1) begin
        chk("drain_in_ready", in_ready, 1);
        chk("drain_level3", level, 3);
      end
    end
    out_ready = 1'b0;
    chk("drain_level0", level, 0);
    chk("drain_idx", out_beat_idx, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idx", out_beat_idx, 0);

    // streaming 16 beats, two stages
    pulses = 0;
    out_ready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      in_valid = (c < 16);
      set_in(256'h100 + c * 16);
      if (c >= 1) begin
        chk($sformatf("stream%0d_d0", c), out_data_0, 256'h100 + (c - 1) * 16);
        chk($sformatf("stream%0d_idx", c), out_beat_idx, (c - 1) % 8);
        chk($sformatf("stream%0d_level", c), level, 1);
      end
      chk($sformatf("stream%0d_sd", c), stage_done, (c >= 2) && ((c - 2) % 8 == 7));
      if (stage_done) pulses++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_last_sd", stage_done, 1);
    if (stage_done) pulses++;
    chk("stream_level_end", level, 0);
    chk("stream_pulses", pulses, 2);
    tick();
    chk("stream_sd_clear", stage_done, 0);

    // random output stalls, 64 beats
    tx = 0; rx = 0; maxlvl = 0;
    for (int cyc = 0; cyc < 2000 && rx < 64; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (tx < 64) && in_ready;
      set_in(256'h1000 + tx * 16);
      if (out_valid && out_ready) begin
        chk($sformatf("rnd%0d_d0", rx), out_data_0, 256'h1000 + rx * 16);
        chk($sformatf("rnd%0d_d5", rx), out_data_5, 256'h1000 + rx * 16 + 5);
        rx++;
      end
      if (in_valid) tx++;
      tick();
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_rx_count", rx, 64);
    chk("rnd_maxlvl_le4", (maxlvl <= 4), 1);
    chk("rnd_level_end", level, 0);
    chk("rnd_idx_end", out_beat_idx, 0);

    // flush mid-stage with a colliding push
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; set_in(256'h200 + i * 16);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("pre_flush_idx", out_beat_idx, 2);
    chk("pre_flush_level", level, 1);
    chk("pre_flush_head", out_data_0, 256'h220);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; set_in(256'h300);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_idx2", out_beat_idx, 0);
    chk("flush_ovf_kept", ovf_err, 1);
    chk("flush_data0", out_data_0, 0);
    tick();
    chk("flush_push_dropped", level, 0);

    // asynchronous reset with level 3
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; set_in(256'h400 + i * 16);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("prerst_level", level, 3);
    chk("prerst_idx", out_beat_idx, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_idx", out_beat_idx, 0);
    chk("arst_ovf", ovf_err, 0);
    chk("arst_data0", out_data_0, 0);
    #1 rst = 1'b0;
    in_valid = 1'b1; set_in(256'h500);
    tick();
    in_valid = 1'b0;
    chk("post_rst_idx", out_beat_idx, 0);
    chk("post_rst_d0", out_data_0, 256'h500);
    chk("post_rst_d7", out_data_7, 256'h507);
    chk("post_rst_level", level, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
